// File: rtl/uart_txn_pkg.sv
// Shared types and width helpers for the UART transaction sequencer.
package uart_txn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_TIMEOUT   = 2'b01,
    ST_FRAME_ERR = 2'b10
  } status_e;

  // Width of a byte-length field able to hold 0..max_len.
  function automatic int len_w_f(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of the inter-byte timeout counter.
  function automatic int to_w_f(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/uart_txn_timeout.sv
// Inter-byte timeout: down counter reloaded to TIMEOUT_CYCLES_P-1, counting
// only while enabled; expired_o is high while enabled and the count is zero.
module uart_txn_timeout
  import uart_txn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES_P = 65535,
  localparam int TO_W = to_w_f(TIMEOUT_CYCLES_P)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LOAD_VAL = TO_W'(TIMEOUT_CYCLES_P - 1);

  logic [TO_W-1:0] cnt_q;

  // Reload on request, otherwise count down to zero and hold there.
  always_ff @(posedge clk) begin
    if (rst || load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_txn_sequencer.sv
// Command/response transaction engine in front of an AXI-stream UART.
// Handshakes: every valid/ready pair transfers exactly on a clock edge where
// both are high; a producer holds valid and data stable until that edge.
module uart_txn_sequencer
  import uart_txn_pkg::*;
#(
  parameter int DATA_WIDTH_P     = 8,
  parameter int MAX_LEN_P        = 8,
  parameter int TIMEOUT_CYCLES_P = 65535,
  localparam int LEN_W = len_w_f(MAX_LEN_P),
  localparam int PKT_W = MAX_LEN_P * DATA_WIDTH_P
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [PKT_W-1:0]        cmd_data_i,
  input  logic [LEN_W-1:0]        cmd_len_i,
  input  logic [LEN_W-1:0]        rsp_len_i,
  output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
  output logic                    tx_tvalid_o,
  input  logic                    tx_tready_i,
  input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
  input  logic                    rx_tvalid_i,
  output logic                    rx_tready_o,
  input  logic                    rx_frame_error_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [PKT_W-1:0]        rsp_data_o,
  output logic [LEN_W-1:0]        rsp_count_o,
  output logic [1:0]              status_o,
  output logic [7:0]              drop_count_o,
  output logic                    busy_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LEN_P);

  state_e           state_q;
  logic [PKT_W-1:0] cmd_buf_q;
  logic [PKT_W-1:0] cmd_next;
  logic [LEN_W-1:0] tx_left_q;
  logic [LEN_W-1:0] rsp_len_q;
  logic [LEN_W-1:0] cmd_len_c;
  logic [LEN_W-1:0] rsp_len_c;
  logic             rx_acc;
  logic             rx_drop;
  logic             to_expired;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  assign cmd_len_c = clamp_len(cmd_len_i);
  assign rsp_len_c = clamp_len(rsp_len_i);
  // Remaining bytes shift down so the next byte to send is always at bit 0.
  assign cmd_next  = cmd_buf_q >> DATA_WIDTH_P;
  assign rx_acc    = rx_tvalid_i && rx_tready_o && (state_q == RECV);
  assign rx_drop   = rx_tvalid_i && rx_tready_o && ((state_q == IDLE) || (state_q == SEND));

  // Held at full count outside RECV, so entry into RECV starts a fresh window.
  uart_txn_timeout #(
    .TIMEOUT_CYCLES_P(TIMEOUT_CYCLES_P)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load_i   ((state_q != RECV) || rx_acc),
    .en_i     (state_q == RECV),
    .expired_o(to_expired)
  );

  // Main sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_buf_q    <= '0;
      tx_left_q    <= '0;
      rsp_len_q    <= '0;
      tx_tvalid_o  <= 1'b0;
      tx_tdata_o   <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_count_o  <= '0;
      status_o     <= ST_OK;
      drop_count_o <= '0;
      cmd_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      rx_tready_o  <= 1'b1;
    end else begin
      if (rx_drop && (drop_count_o != 8'hFF)) begin
        drop_count_o <= drop_count_o + 8'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_buf_q   <= cmd_data_i;
            tx_left_q   <= cmd_len_c;
            rsp_len_q   <= rsp_len_c;
            rsp_data_o  <= '0;
            rsp_count_o <= '0;
            status_o    <= ST_OK;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (cmd_len_c != '0) begin
              state_q     <= SEND;
              tx_tvalid_o <= 1'b1;
              tx_tdata_o  <= cmd_data_i[DATA_WIDTH_P-1:0];
            end else if (rsp_len_c != '0) begin
              state_q <= RECV;
            end else begin
              state_q     <= DONE;
              rsp_valid_o <= 1'b1;
              rx_tready_o <= 1'b0;
            end
          end
        end
        SEND: begin
          if (tx_tready_i) begin
            if (tx_left_q == LEN_W'(1)) begin
              tx_tvalid_o <= 1'b0;
              tx_tdata_o  <= '0;
              if (rsp_len_q != '0) begin
                state_q <= RECV;
              end else begin
                state_q     <= DONE;
                rsp_valid_o <= 1'b1;
                rx_tready_o <= 1'b0;
              end
            end else begin
              tx_left_q  <= tx_left_q - 1'b1;
              cmd_buf_q  <= cmd_next;
              tx_tdata_o <= cmd_next[DATA_WIDTH_P-1:0];
            end
          end
        end
        RECV: begin
          if (rx_acc) begin
            for (int k = 0; k < MAX_LEN_P; k++) begin
              if (rsp_count_o == LEN_W'(k)) begin
                rsp_data_o[k*DATA_WIDTH_P +: DATA_WIDTH_P] <= rx_tdata_i;
              end
            end
            rsp_count_o <= rsp_count_o + 1'b1;
          end
          if (rx_frame_error_i) begin
            state_q     <= DONE;
            status_o    <= ST_FRAME_ERR;
            rsp_valid_o <= 1'b1;
            rx_tready_o <= 1'b0;
          end else if (rx_acc && (LEN_W'(rsp_count_o + 1'b1) == rsp_len_q)) begin
            state_q     <= DONE;
            status_o    <= ST_OK;
            rsp_valid_o <= 1'b1;
            rx_tready_o <= 1'b0;
          end else if (!rx_acc && to_expired) begin
            state_q     <= DONE;
            status_o    <= ST_TIMEOUT;
            rsp_valid_o <= 1'b1;
            rx_tready_o <= 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rx_tready_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txn_sequencer.sv
// Directed bench for uart_txn_sequencer with queue-based tx/rsp scoreboards.
module tb_uart_txn_sequencer;

  localparam int DW = 8;
  localparam int ML = 8;
  localparam int TO = 100;
  localparam int LW = 4;
  localparam int PW = ML * DW;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [LW-1:0] cnt;
    logic [1:0]    st;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [PW-1:0] cmd_data_i;
  logic [LW-1:0] cmd_len_i;
  logic [LW-1:0] rsp_len_i;
  logic [DW-1:0] tx_tdata_o;
  logic          tx_tvalid_o;
  logic          tx_tready_i;
  logic [DW-1:0] rx_tdata_i;
  logic          rx_tvalid_i;
  logic          rx_tready_o;
  logic          rx_frame_error_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [PW-1:0] rsp_data_o;
  logic [LW-1:0] rsp_count_o;
  logic [1:0]    status_o;
  logic [7:0]    drop_count_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] tx_exp_q[$];
  rsp_t          rsp_exp_q[$];

  uart_txn_sequencer #(
    .DATA_WIDTH_P    (DW),
    .MAX_LEN_P       (ML),
    .TIMEOUT_CYCLES_P(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_data_i      (cmd_data_i),
    .cmd_len_i       (cmd_len_i),
    .rsp_len_i       (rsp_len_i),
    .tx_tdata_o      (tx_tdata_o),
    .tx_tvalid_o     (tx_tvalid_o),
    .tx_tready_i     (tx_tready_i),
    .rx_tdata_i      (rx_tdata_i),
    .rx_tvalid_i     (rx_tvalid_i),
    .rx_tready_o     (rx_tready_o),
    .rx_frame_error_i(rx_frame_error_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_data_o      (rsp_data_o),
    .rsp_count_o     (rsp_count_o),
    .status_o        (status_o),
    .drop_count_o    (drop_count_o),
    .busy_o          (busy_o)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tx monitor: checks byte order on every handshake and stability while stalled.
  logic          tx_held = 1'b0;
  logic [DW-1:0] tx_held_data;
  logic [DW-1:0] tx_exp_b;
  always @(negedge clk) begin
    if (rst) begin
      tx_held = 1'b0;
    end else begin
      if (tx_held && tx_tvalid_o) check("tx_hold_stable", tx_tdata_o, tx_held_data);
      if (tx_tvalid_o && tx_tready_i) begin
        if (tx_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_extra: got byte %0h expected no byte", tx_tdata_o);
        end else begin
          tx_exp_b = tx_exp_q.pop_front();
          check("tx_byte", tx_tdata_o, tx_exp_b);
        end
      end
      tx_held      = tx_tvalid_o && !tx_tready_i;
      tx_held_data = tx_tdata_o;
    end
  end

  // rsp monitor: compares each presented result against the expected queue.
  rsp_t rsp_exp_r;
  always @(negedge clk) begin
    if (!rst && rsp_valid_o && rsp_ready_i) begin
      if (rsp_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_extra: got status %0h count %0d expected no response", status_o, rsp_count_o);
      end else begin
        rsp_exp_r = rsp_exp_q.pop_front();
        check("rsp_data", rsp_data_o, rsp_exp_r.data);
        check("rsp_count", PW'(rsp_count_o), PW'(rsp_exp_r.cnt));
        check("rsp_status", PW'(status_o), PW'(rsp_exp_r.st));
      end
    end
  end

  task automatic push_rsp(input logic [PW-1:0] data, input int cnt, input logic [1:0] st);
    rsp_t r;
    r.data = data;
    r.cnt  = LW'(cnt);
    r.st   = st;
    rsp_exp_q.push_back(r);
  endtask

  task automatic do_cmd(input logic [PW-1:0] data, input int cl, input int rl);
    int w = 0;
    int n_tx;
    while (!cmd_ready_o && w < 200) begin
      tick();
      w++;
    end
    check("cmd_ready_before_accept", PW'(cmd_ready_o), PW'(1));
    n_tx = (cl > ML) ? ML : cl;
    for (int k = 0; k < n_tx; k++) tx_exp_q.push_back(data[k*DW +: DW]);
    cmd_data_i  = data;
    cmd_len_i   = LW'(cl);
    rsp_len_i   = LW'(rl);
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    check("busy_after_accept", PW'(busy_o), PW'(1));
    check("first_tx_latency", PW'(tx_tvalid_o), PW'(cl > 0));
  endtask

  task automatic send_rx(input logic [DW-1:0] b);
    int   w  = 0;
    logic ok = 1'b0;
    rx_tdata_i  = b;
    rx_tvalid_i = 1'b1;
    do begin
      @(negedge clk);
      ok = rx_tready_o;
      tick();
      w++;
    end while (!ok && w < 200);
    rx_tvalid_i = 1'b0;
    check("rx_accepted", PW'(ok), PW'(1));
  endtask

  task automatic wait_tx_done();
    int w = 0;
    while (tx_exp_q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    check("tx_drained", PW'(tx_exp_q.size()), PW'(0));
  endtask

  task automatic wait_rsp_done();
    int w = 0;
    while (rsp_exp_q.size() != 0 && w < 500) begin
      tick();
      w++;
    end
    check("rsp_drained", PW'(rsp_exp_q.size()), PW'(0));
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", PW'(cmd_ready_o), PW'(1));
    check("rst_rx_tready", PW'(rx_tready_o), PW'(1));
    check("rst_tx_tvalid", PW'(tx_tvalid_o), PW'(0));
    check("rst_tx_tdata", PW'(tx_tdata_o), PW'(0));
    check("rst_rsp_valid", PW'(rsp_valid_o), PW'(0));
    check("rst_rsp_data", rsp_data_o, PW'(0));
    check("rst_rsp_count", PW'(rsp_count_o), PW'(0));
    check("rst_status", PW'(status_o), PW'(0));
    check("rst_drop_count", PW'(drop_count_o), PW'(0));
    check("rst_busy", PW'(busy_o), PW'(0));
  endtask

  // Directed stimulus.
  initial begin
    int n;
    rst              = 1'b1;
    cmd_valid_i      = 1'b0;
    cmd_data_i       = '0;
    cmd_len_i        = '0;
    rsp_len_i        = '0;
    tx_tready_i      = 1'b1;
    rx_tdata_i       = '0;
    rx_tvalid_i      = 1'b0;
    rx_frame_error_i = 1'b0;
    rsp_ready_i      = 1'b1;
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    // Loopback ALU op: A5 03 05 out, 08 back.
    push_rsp(64'h08, 1, 2'b00);
    do_cmd(64'h0000_0000_0005_03A5, 3, 1);
    wait_tx_done();
    send_rx(8'h08);
    wait_rsp_done();

    // Backpressure for 20 cycles after the first byte.
    push_rsp(64'h0, 0, 2'b00);
    do_cmd(64'h0000_0000_4433_2211, 4, 0);
    tick();
    tx_tready_i = 1'b0;
    repeat (20) tick();
    tx_tready_i = 1'b1;
    wait_tx_done();
    wait_rsp_done();

    // Timeout: two bytes expected, one returned.
    push_rsp(64'h7E, 1, 2'b01);
    do_cmd(64'h42, 1, 2);
    wait_tx_done();
    send_rx(8'h7E);
    n = 0;
    while (!rsp_valid_o && n < 300) begin
      tick();
      n++;
    end
    check("timeout_latency", PW'(n), PW'(100));
    wait_rsp_done();

    // Frame error with a byte in the same cycle, then a fresh command.
    push_rsp(64'h3231, 2, 2'b10);
    do_cmd(64'hBEEF, 2, 3);
    wait_tx_done();
    send_rx(8'h31);
    rx_tdata_i       = 8'h32;
    rx_tvalid_i      = 1'b1;
    rx_frame_error_i = 1'b1;
    tick();
    rx_tvalid_i      = 1'b0;
    rx_frame_error_i = 1'b0;
    wait_rsp_done();
    push_rsp(64'h55, 1, 2'b00);
    do_cmd(64'h12, 1, 1);
    wait_tx_done();
    send_rx(8'h55);
    wait_rsp_done();

    // Stray bytes in IDLE: 3, then 300 in total to saturate.
    for (int i = 0; i < 3; i++) send_rx(8'(i + 1));
    check("drop_count_3", PW'(drop_count_o), PW'(3));
    rx_tdata_i  = 8'hEE;
    rx_tvalid_i = 1'b1;
    repeat (297) tick();
    rx_tvalid_i = 1'b0;
    check("drop_count_sat", PW'(drop_count_o), PW'(255));

    // Zero-length command and response: result one cycle after accept.
    push_rsp(64'h0, 0, 2'b00);
    do_cmd(64'h99, 0, 0);
    check("zero_len_rsp_latency", PW'(rsp_valid_o), PW'(1));
    wait_rsp_done();
    push_rsp(64'h9C, 1, 2'b00);
    do_cmd(64'h77, 1, 1);
    wait_tx_done();
    send_rx(8'h9C);
    wait_rsp_done();
    check("drop_count_held", PW'(drop_count_o), PW'(255));

    // Over-long command clamps to MAX_LEN_P bytes.
    push_rsp(64'h0, 0, 2'b00);
    do_cmd(64'h0807_0605_0403_0201, ML + 3, 0);
    wait_tx_done();
    wait_rsp_done();
    repeat (3) tick();

    // Reset while stalled in SEND aborts with no result.
    tx_tready_i = 1'b0;
    do_cmd(64'hDDCC_BBAA, 4, 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_reset_vals();
    tx_exp_q.delete();
    rst         = 1'b0;
    tx_tready_i = 1'b1;
    repeat (10) tick();
    push_rsp(64'h5A, 1, 2'b00);
    do_cmd(64'h01, 1, 1);
    wait_tx_done();
    send_rx(8'h5A);
    wait_rsp_done();
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_txn_sequencer.md
Name: uart_txn_sequencer

Overview:
- Synthesizable transaction engine for the UART ALU link.
- Accepts one multi-byte command packet and streams it byte-by-byte into an AXI-stream UART transmitter.
- Collects a response of programmable length from the UART receiver, with an inter-byte timeout and error status.
- Sits between a host/test controller and the uart core (s_axis/m_axis side). It replaces hand-driven single-byte send/wait sequencing.

Parameters:
- DATA_WIDTH_P, 8, bits per UART byte (matches uart DATA_WIDTH).
- MAX_LEN_P, 8, maximum command and response length in bytes (>=1).
- TIMEOUT_CYCLES_P, 65535, idle clk cycles allowed between response bytes (>=2).
- Derived: LEN_W = $clog2(MAX_LEN_P+1); TO_W = $clog2(TIMEOUT_CYCLES_P+1).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command packet offered.
- cmd_ready_o  out  1  sequencer idle, packet accepted when valid&ready.
- cmd_data_i  in  MAX_LEN_P*DATA_WIDTH_P  packet bytes; byte k = [k*DW +: DW]; byte 0 sent first.
- cmd_len_i  in  LEN_W  bytes to send.
- rsp_len_i  in  LEN_W  bytes expected back.
- tx_tdata_o  out  DATA_WIDTH_P  to uart s_axis_tdata.
- tx_tvalid_o  out  1  to uart s_axis_tvalid.
- tx_tready_i  in  1  from uart s_axis_tready.
- rx_tdata_i  in  DATA_WIDTH_P  from uart m_axis_tdata.
- rx_tvalid_i  in  1  from uart m_axis_tvalid.
- rx_tready_o  out  1  to uart m_axis_tready.
- rx_frame_error_i  in  1  from uart rx_frame_error.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  result consumed.
- rsp_data_o  out  MAX_LEN_P*DATA_WIDTH_P  response bytes; byte k at [k*DW +: DW]; unused bytes 0.
- rsp_count_o  out  LEN_W  response bytes actually received.
- status_o  out  2  00 OK, 01 TIMEOUT, 10 FRAME_ERR.
- drop_count_o  out  8  saturating count of rx bytes discarded outside RECV.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; cmd_ready_o=1. All other outputs are 0: tx_tvalid_o, tx_tdata_o, rsp_valid_o, rsp_data_o, rsp_count_o, status_o, drop_count_o, busy_o. rx_tready_o=1.
- Reset mid-operation aborts the transaction immediately. No partial result is presented. A byte already handed to the uart is not recalled.
- States: IDLE, SEND, RECV, DONE.
- IDLE:
  - On cmd_valid_i&cmd_ready_o, latch cmd_data_i, cmd_len_i and rsp_len_i. Lengths > MAX_LEN_P clamp to MAX_LEN_P.
  - Clear rsp_data_o, rsp_count_o and status_o.
  - Next state: SEND if cmd_len>0; else RECV if rsp_len>0; else DONE.
  - cmd_ready_o is 1 only in IDLE.
- SEND:
  - tx_tvalid_o=1 and tx_tdata_o=byte[idx], both registered.
  - On tx_tvalid_o&tx_tready_i, idx increments and the next byte is presented in the following cycle. Back-to-back bytes are allowed.
  - tx_tdata_o is held stable while tx_tvalid_o=1 and tx_tready_i=0.
  - After the last handshake, tx_tvalid_o=0. Next state: RECV if rsp_len>0, else DONE.
- RECV:
  - On entry, clear the timeout counter.
  - Each rx_tvalid_i&rx_tready_o stores rx_tdata_i at rsp_data_o[rsp_count*DW], increments rsp_count_o and clears the timeout counter.
  - rsp_count reaching rsp_len: go to DONE with status OK.
  - Timeout counter reaching TIMEOUT_CYCLES_P-1 with no byte in that cycle: go to DONE with status TIMEOUT.
  - rx_frame_error_i=1: go to DONE with status FRAME_ERR. A byte valid in the same cycle is still stored. FRAME_ERR has priority over OK and TIMEOUT.
- DONE:
  - rsp_valid_o=1. rsp_data_o, rsp_count_o and status_o are held stable until rsp_valid_o&rsp_ready_i.
  - rx_tready_o=0, so bytes back-pressure into the uart.
  - After the handshake: state=IDLE; rsp_valid_o=0 next cycle.
- rx outside RECV:
  - rx_tready_o=1 in IDLE and SEND. Accepted bytes are discarded and drop_count_o increments, saturating at 255.
  - drop_count_o is cleared only by rst.
- Latency: command accept to first tx_tvalid_o = 1 cycle. Final rx byte to rsp_valid_o = 1 cycle. rsp_len=cmd_len=0 gives rsp_valid_o 1 cycle after accept, status OK.

Decomposition:
- Package uart_txn_pkg holds:
  - state_e enum {IDLE, SEND, RECV, DONE};
  - status_e enum {ST_OK=2'b00, ST_TIMEOUT=2'b01, ST_FRAME_ERR=2'b10};
  - LEN_W/TO_W helper functions.
- One sub-module: uart_txn_timeout. It is a loadable/clearable down counter with an expiry pulse, parametrised by TIMEOUT_CYCLES_P.

Test Plan:
- Loopback ALU op: cmd bytes {0xA5,0x03,0x05}, cmd_len=3, rsp_len=1, reply 0x08 -> tx order A5,03,05; rsp_data byte0=0x08, rsp_count=1, status=00.
- Backpressure: hold tx_tready_i=0 for 20 cycles mid-packet -> tx_tdata_o stable and no byte skipped or duplicated. Then 4 bytes 0x11..0x44 are sent in order.
- Timeout: TIMEOUT_CYCLES_P=100, rsp_len=2, only 1 byte (0x7E) returned -> status=01, rsp_count=1, byte0=0x7E, rsp_valid_o 100 cycles after that byte.
- Frame error: assert rx_frame_error_i one cycle during RECV -> status=10 and DONE; a new cmd is accepted after the rsp handshake.
- Stray bytes: 3 rx bytes in IDLE, 300 in total later -> drop_count_o=3, then saturates at 255. Subsequent transaction is unaffected.
- Edge lengths: cmd_len=0/rsp_len=0 -> rsp_valid_o 1 cycle after accept, status 00. cmd_len=MAX_LEN_P+3 -> exactly MAX_LEN_P bytes sent. rst during SEND -> IDLE, outputs at reset values next cycle.
